// File: rtl/mouse_pos_sync.sv
// Synchronises raw MouseCtl position/buttons into the pixel domain and updates the
// cursor position once per frame at vblank start. Optional clamp: MOUSE_POS_CLAMP_EN.
module mouse_pos_sync #(
    parameter int W             = 12,
    parameter int STABLE_CYCLES = 4,
    parameter int XMAX          = 1023,
    parameter int YMAX          = 767
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] xpos_in,
    input  logic [W-1:0] ypos_in,
    input  logic         left_in,
    input  logic         right_in,
    input  logic         vblank,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic         left,
    output logic         right,
    output logic         right_click,
    output logic         frame_tick
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [W-1:0]  XLIM    = W'(XMAX);
    localparam logic [W-1:0]  YLIM    = W'(YMAX);
`ifdef MOUSE_POS_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [2*W-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, pos_q, pos_d;
    logic [1:0]     btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic           b3_q, b3_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           vblank_d_q, vblank_d_d;
    logic           frame_tick_q, frame_tick_d;
    logic           right_click_q, right_click_d;
    logic           rise;
    logic [W-1:0]   x_cl, y_cl;

    always_comb begin
        s1_d       = {xpos_in, ypos_in};
        s2_d       = s1_q;
        btn_s1_d   = {left_in, right_in};
        btn_s2_d   = btn_s1_q;
        b3_d       = btn_s2_q[0];
        vblank_d_d = vblank;

        // Saturating count of consecutive cycles with identical synchronised samples.
        if (s1_q == s2_q)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        else
            cnt_d = '0;

        cand_d = (cnt_q == CNT_MAX) ? s2_q : cand_q;

        x_cl = (CLAMP_EN && (cand_q[2*W-1:W] > XLIM)) ? XLIM : cand_q[2*W-1:W];
        y_cl = (CLAMP_EN && (cand_q[W-1:0]   > YLIM)) ? YLIM : cand_q[W-1:0];

        // Registered cand is used, so a cand update on the rise edge lands next frame.
        rise         = vblank & ~vblank_d_q;
        pos_d        = pos_q;
        frame_tick_d = 1'b0;
        if (rise) begin
            pos_d        = {x_cl, y_cl};
            frame_tick_d = 1'b1;
        end

        right_click_d = btn_s2_q[0] & ~b3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            b3_q          <= 1'b0;
            cnt_q         <= '0;
            cand_q        <= '0;
            vblank_d_q    <= 1'b0;
            pos_q         <= '0;
            frame_tick_q  <= 1'b0;
            right_click_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            b3_q          <= b3_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            vblank_d_q    <= vblank_d_d;
            pos_q         <= pos_d;
            frame_tick_q  <= frame_tick_d;
            right_click_q <= right_click_d;
        end
    end

    assign xpos        = pos_q[2*W-1:W];
    assign ypos        = pos_q[W-1:0];
    assign left        = btn_s2_q[1];
    assign right       = btn_s2_q[0];
    assign right_click = right_click_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_mouse_pos_sync.sv
// Directed bench for mouse_pos_sync: reset, frame latch, jitter, clamp, click, simultaneous update.
module tb_mouse_pos_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos_in, ypos_in;
    logic        left_in, right_in, vblank;
    logic [11:0] xpos, ypos;
    logic        left, right, right_click, frame_tick;

    int total = 0;
    int bad   = 0;

    mouse_pos_sync dut (
        .clk(clk), .rst(rst),
        .xpos_in(xpos_in), .ypos_in(ypos_in),
        .left_in(left_in), .right_in(right_in), .vblank(vblank),
        .xpos(xpos), .ypos(ypos), .left(left), .right(right),
        .right_click(right_click), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic hold_pos(input logic [11:0] x, input logic [11:0] y, input int n);
        xpos_in = x;
        ypos_in = y;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vblank_rise();
        vblank = 1'b1;
        tick();
    endtask

    logic [11:0] cx, cy;
    int clicks;

    initial begin
        rst = 1'b1; xpos_in = 12'd100; ypos_in = 12'd0;
        left_in = 1'b0; right_in = 1'b0; vblank = 1'b0;

        // reset with vblank toggling: nothing may come out
        for (int i = 0; i < 3; i++) begin
            vblank = ~vblank;
            tick();
            chk("rst_tick", 32'(frame_tick), 0);
            chk("rst_x", 32'(xpos), 0);
        end
        rst = 1'b0; vblank = 1'b0;
        tick();
        chk("post_rst_x", 32'(xpos), 0);
        chk("post_rst_y", 32'(ypos), 0);
        chk("post_rst_tick", 32'(frame_tick), 0);
        chk("post_rst_click", 32'(right_click), 0);
        chk("post_rst_lr", 32'({left, right}), 0);

        // stable position then a vblank rise; left button through the 2-FF chain
        left_in = 1'b1;
        xpos_in = 12'd300; ypos_in = 12'd200;
        tick();
        chk("left_lat1", 32'(left), 0);
        tick();
        chk("left_lat2", 32'(left), 1);
        hold_pos(12'd300, 12'd200, 8);
        chk("pre_rise_x", 32'(xpos), 0);
        vblank_rise();
        chk("stable_x", 32'(xpos), 300);
        chk("stable_y", 32'(ypos), 200);
        chk("stable_tick", 32'(frame_tick), 1);
        tick();
        chk("tick_once", 32'(frame_tick), 0);
        tick();
        chk("vb_held_noretrig", 32'(frame_tick), 0);
        vblank = 1'b0;
        tick();

        // jitter across a vblank rise: position must not move
        for (int i = 0; i < 12; i++) begin
            xpos_in = (i % 2 == 1) ? 12'd51 : 12'd50;
            if (i == 6) vblank = 1'b1;
            tick();
            if (i == 6) begin
                chk("jitter_x", 32'(xpos), 300);
                chk("jitter_tick", 32'(frame_tick), 1);
            end
        end
        vblank = 1'b0;
        tick();

        // out-of-range position
`ifdef MOUSE_POS_CLAMP_EN
        cx = 12'd1023; cy = 12'd767;
`else
        cx = 12'd1500; cy = 12'd900;
`endif
        hold_pos(12'd1500, 12'd900, 10);
        vblank_rise();
        chk("clamp_x", 32'(xpos), 32'(cx));
        chk("clamp_y", 32'(ypos), 32'(cy));
        vblank = 1'b0;
        tick();

        // right button held 20 cycles: one click pulse, 3 cycles after the press
        right_in = 1'b1;
        clicks = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (right_click) clicks++;
            if (i == 1) chk("right_lat1", 32'(right), 0);
            if (i == 2) chk("click_c2", 32'(right_click), 0);
            if (i == 3) chk("click_c3", 32'(right_click), 1);
            if (i == 4) chk("click_c4", 32'(right_click), 0);
            if (i == 20) chk("right_held", 32'(right), 1);
        end
        chk("click_count", 32'(clicks), 1);
        right_in = 1'b0;
        tick();

        // cand updates on the same edge as the vblank rise: old value is latched
        xpos_in = 12'd400; ypos_in = 12'd300;
        for (int i = 0; i < 6; i++) tick();
        vblank_rise();
        chk("simul_old_x", 32'(xpos), 32'(cx));
        chk("simul_old_y", 32'(ypos), 32'(cy));
        chk("simul_tick", 32'(frame_tick), 1);
        vblank = 1'b0;
        tick(); tick();
        vblank_rise();
        chk("simul_new_x", 32'(xpos), 400);
        chk("simul_new_y", 32'(ypos), 300);
        vblank = 1'b0;
        tick();

        // mid-run reset clears the latched position
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rerst_x", 32'(xpos), 0);
        chk("rerst_tick", 32'(frame_tick), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
